// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the key matrix scanner.
// Holds the scan state encoding, the key-index width helper and the
// lowest-set-bit priority function used to pick which key to report.
package keypad_pkg;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        EVAL   = 2'd3
    } scan_state_e;

    // Widest key vector the priority helper accepts.
    localparam int MAX_KEYS = 64;

    // Width of an index into a set of n items (never less than one bit).
    function automatic int key_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index width for the default 4x4 matrix.
    localparam int KEY_IDX_W = key_idx_w(16);

    // Index of the lowest set bit of v; 0 when v is empty.
    function automatic int lowest_set(input logic [MAX_KEYS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            idx = v[i] ? i : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_event_reg.sv
// keypad_event_reg: one-entry valid/ready output register.
// A new event is loaded when the register is empty or is being emptied in
// the same cycle; otherwise the event is dropped and overflow pulses once.
// Code and release flag stay frozen while the consumer stalls.
module keypad_event_reg #(
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_release,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic              out_release,
    output logic              overflow
);

    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              release_q, release_d;
    logic              overflow_q, overflow_d;

    // Next-state: load, drop with overflow pulse, or retire on handshake.
    always_comb begin
        valid_d    = valid_q;
        code_d     = code_q;
        release_d  = release_q;
        overflow_d = 1'b0;
        if (in_valid && (!valid_q || out_ready)) begin
            valid_d   = 1'b1;
            code_d    = in_code;
            release_d = in_release;
        end else if (in_valid) begin
            overflow_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            code_q     <= '0;
            release_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            code_q     <= code_d;
            release_q  <= release_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_code    = code_q;
    assign out_release = release_q;
    assign overflow    = overflow_q;

endmodule

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: 4x4 passive key matrix scanner.
// Drives one column low at a time, samples the active-low rows after a
// settle delay, debounces whole 16-key snapshots and reports the lowest new
// press through keypad_event_reg.
// Optional feature: define KEYPAD_RELEASE_EVENT_EN to also report key
// releases (key_release=1) when no press is reported at the same accept point.
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3,
    localparam int NK            = ROWS * COLS,
    localparam int KW            = key_idx_w(NK)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row_sense,
    output logic [COLS-1:0] col_drive,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    output logic            key_release,
    input  logic            key_ready,
    output logic            key_overflow
);

    localparam int CW = key_idx_w(COLS);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    scan_state_e     state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [NK-1:0]   snapshot_q, snapshot_d;
    logic [NK-1:0]   prev_q, prev_d;
    logic [NK-1:0]   debounced_q, debounced_d;
    logic [DW-1:0]   stable_q, stable_d;
    logic [COLS-1:0] col_drive_q, col_drive_d;

    logic [NK-1:0]       new_press_s;
    logic [MAX_KEYS-1:0] pick_s;
    logic                ev_valid_s;
    logic [KW-1:0]       ev_code_s;
    logic                ev_release_s;
`ifdef KEYPAD_RELEASE_EVENT_EN
    logic [NK-1:0]       new_rel_s;
`endif

    // Scan sequencer, snapshot capture and debounce/event decision.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        settle_d     = settle_q;
        snapshot_d   = snapshot_q;
        prev_d       = prev_q;
        debounced_d  = debounced_q;
        stable_d     = stable_q;
        new_press_s  = '0;
        pick_s       = '0;
        ev_valid_s   = 1'b0;
        ev_code_s    = '0;
        ev_release_s = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
        new_rel_s    = '0;
`endif
        case (state_q)
            DRIVE: begin
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            SAMPLE: begin
                for (int r = 0; r < ROWS; r++) begin
                    snapshot_d[r*COLS + int'(col_q)] = ~row_sense[r];
                end
                if (col_q == CW'(COLS - 1)) begin
                    state_d = EVAL;
                end else begin
                    col_d   = col_q + CW'(1);
                    state_d = DRIVE;
                end
            end
            EVAL: begin
                col_d   = '0;
                state_d = DRIVE;
                if (snapshot_q == prev_q) begin
                    stable_d = (stable_q >= DW'(DEBOUNCE_SCANS)) ?
                               DW'(DEBOUNCE_SCANS) : stable_q + DW'(1);
                end else begin
                    stable_d = DW'(1);
                end
                prev_d = snapshot_q;
                // Accept point: a snapshot that has held long enough and differs.
                if ((stable_d == DW'(DEBOUNCE_SCANS)) && (snapshot_q != debounced_q)) begin
                    new_press_s = snapshot_q & ~debounced_q;
                    debounced_d = snapshot_q;
`ifdef KEYPAD_RELEASE_EVENT_EN
                    new_rel_s = debounced_q & ~snapshot_q;
                    if (new_press_s != '0) begin
                        pick_s[NK-1:0] = new_press_s;
                        ev_valid_s     = 1'b1;
                        ev_release_s   = 1'b0;
                    end else if (new_rel_s != '0) begin
                        pick_s[NK-1:0] = new_rel_s;
                        ev_valid_s     = 1'b1;
                        ev_release_s   = 1'b1;
                    end else begin
                        ev_valid_s = 1'b0;
                    end
`else
                    if (new_press_s != '0) begin
                        pick_s[NK-1:0] = new_press_s;
                        ev_valid_s     = 1'b1;
                    end else begin
                        ev_valid_s = 1'b0;
                    end
`endif
                    ev_code_s = KW'(lowest_set(pick_s));
                end else begin
                    debounced_d = debounced_q;
                end
            end
            default: begin
                state_d = DRIVE;
                col_d   = '0;
            end
        endcase
        // Column drive follows the upcoming state so the output is registered.
        for (int c = 0; c < COLS; c++) begin
            col_drive_d[c] = !((state_d != EVAL) && (col_d == CW'(c)));
        end
    end

    // Scan state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DRIVE;
            col_q       <= '0;
            settle_q    <= '0;
            snapshot_q  <= '0;
            prev_q      <= '0;
            debounced_q <= '0;
            stable_q    <= '0;
            col_drive_q <= '1;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            settle_q    <= settle_d;
            snapshot_q  <= snapshot_d;
            prev_q      <= prev_d;
            debounced_q <= debounced_d;
            stable_q    <= stable_d;
            col_drive_q <= col_drive_d;
        end
    end

    assign col_drive = col_drive_q;

    keypad_event_reg #(
        .CODE_W (KW)
    ) u_event_reg (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (ev_valid_s),
        .in_code     (ev_code_s),
        .in_release  (ev_release_s),
        .out_ready   (key_ready),
        .out_valid   (key_valid),
        .out_code    (key_code),
        .out_release (key_release),
        .overflow    (key_overflow)
    );

endmodule

// File: doc/keypad_matrix_scan.md
Name: keypad_matrix_scan

Overview:
Scanner for a 4x4 passive key matrix on the board header.
- Drives one column low at a time and samples active-low row lines.
- Debounces the complete 16-key snapshot and emits key press events through a one-entry valid/ready output register.
- Mirrors the LED matrix scan logic in the input direction: it reads a matrix, where the display block writes one.

Parameters:
- ROWS, 4, number of row sense lines.
- COLS, 4, number of column drive lines.
- SETTLE_CYCLES, 4, wait cycles after a column is driven before sampling; at least 1.
- DEBOUNCE_SCANS, 3, number of consecutive identical full scans required before a snapshot is accepted; at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- row_sense  in  ROWS  row inputs; active-low, pulled up externally.
- col_drive  out  COLS  column drives; active-low, at most one bit low at a time.
- key_valid  out  1  event pending.
- key_code  out  $clog2(ROWS*COLS)  key index = row*COLS + col.
- key_release  out  1  event is a release (see Optional Feature).
- key_ready  in  1  consumer accepts the event.
- key_overflow  out  1  one-cycle pulse when an event is dropped.

Behaviour:
- Reset values: state DRIVE, col=0, col_drive all ones, key_valid=0, key_code=0, key_release=0, key_overflow=0, snapshot/prev/debounced=0, stable_cnt=0.
- FSM states:
  - DRIVE: 1 cycle; col_drive[col] driven low.
  - SETTLE: SETTLE_CYCLES cycles; same drive.
  - SAMPLE: 1 cycle; same drive; snapshot[r*COLS+col] <= ~row_sense[r] for every r.
    - If col==COLS-1 go to EVAL; else col+1 and go to DRIVE.
  - EVAL: 1 cycle; col_drive all ones; col <= 0; then go to DRIVE.
- Scan period is COLS*(SETTLE_CYCLES+2)+1 cycles (25 with defaults).
- EVAL debounce rules:
  - If snapshot==prev, stable_cnt <= min(stable_cnt+1, DEBOUNCE_SCANS).
  - Otherwise stable_cnt <= 1.
  - prev <= snapshot in every EVAL.
  - When the updated stable_cnt==DEBOUNCE_SCANS and snapshot!=debounced:
    - new_press = snapshot & ~debounced.
    - debounced <= snapshot.
    - If new_press!=0, generate a press event for the lowest set index.
  - Other simultaneous new presses are absorbed into debounced without an event; they are not reported later.
- Event latency: key_valid rises the cycle after EVAL.
- Output handshake:
  - An event is loaded into key_valid/key_code/key_release when key_valid==0, or when key_valid&&key_ready in the same cycle (replace).
  - When key_valid&&!key_ready the event is dropped and key_overflow pulses for 1 cycle.
  - key_code and key_release are held stable while key_valid && !key_ready.
  - key_valid&&key_ready with no new event clears key_valid the next cycle.
- rst asserted mid-scan: all state returns to reset values on that edge and any pending event is lost.
- key_ready is ignored while key_valid==0.

Optional Feature:
Macro KEYPAD_RELEASE_EVENT_EN.
- Defined:
  - Also compute new_rel = debounced & ~snapshot at the same accept point.
  - If a press exists, the press is reported (priority).
  - Otherwise the lowest new_rel index is reported with key_release=1.
  - Handshake and overflow rules are unchanged.
- Undefined: key_release is tied to 0 and releases only update debounced.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (DRIVE, SETTLE, SAMPLE, EVAL);
  - a KEY_IDX_W localparam function;
  - a lowest-set-bit priority function.
- One sub-module, keypad_event_reg: the one-entry valid/ready output register with overflow pulse. It is reusable by the LED display command path.

Test Plan:
- Reset then idle, all row_sense=4'hF for 200 cycles -> col_drive cycles 1110,1101,1011,0111 each held 6 cycles, then 1111 for 1 cycle; key_valid stays 0.
- Key row1/col2 held from cycle 10 for 200 cycles, key_ready=1 -> exactly one event, key_code=6, key_valid high 1 cycle, asserted after the EVAL of the third complete scan.
- Key 6 glitch of 30 cycles (about 1 scan) -> no event, debounced unchanged.
- Keys 3 and 9 pressed together and held, key_ready=1 -> single event key_code=3.
- key_ready=0, press key 6 and release, then press key 12 -> key_valid holds key_code=6; key_overflow pulses once at the accept point for 12; raising key_ready clears key_valid.
- rst pulsed mid-SETTLE with an event pending -> next cycle key_valid=0, col_drive=1111, then DRIVE col 0.
- With KEYPAD_RELEASE_EVENT_EN, press then release key 5 -> two events: code 5 with key_release=0, then code 5 with key_release=1.
